// File: rtl/spad_arbiter_if.sv
// spad_arbiter_if: requester-side read/write handshake plus scratchpad port drive.
// slave = arbiter view, master = requester/scratchpad view.
interface spad_arbiter_if #(
  parameter int unsigned DATA_BITWIDTH = 16,
  parameter int unsigned ADDR_BITWIDTH = 9
);
  // Requester read port
  logic [1:0]                   rd_req;
  logic [2*ADDR_BITWIDTH-1:0]   rd_addr;
  logic [1:0]                   rd_gnt;
  logic [1:0]                   rd_valid;
  logic [DATA_BITWIDTH-1:0]     rd_data;
  // Requester write port
  logic [1:0]                   wr_req;
  logic [2*ADDR_BITWIDTH-1:0]   wr_addr;
  logic [2*DATA_BITWIDTH-1:0]   wr_data;
  logic [1:0]                   wr_gnt;
  // Scratchpad side
  logic                         sp_read_req;
  logic [ADDR_BITWIDTH-1:0]     sp_r_addr;
  logic                         sp_write_en;
  logic [ADDR_BITWIDTH-1:0]     sp_w_addr;
  logic [DATA_BITWIDTH-1:0]     sp_w_data;
  logic [DATA_BITWIDTH-1:0]     sp_r_data;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, sp_r_data,
    output rd_gnt, rd_valid, rd_data, wr_gnt,
    output sp_read_req, sp_r_addr, sp_write_en, sp_w_addr, sp_w_data
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, sp_r_data,
    input  rd_gnt, rd_valid, rd_data, wr_gnt,
    input  sp_read_req, sp_r_addr, sp_write_en, sp_w_addr, sp_w_data
  );
endinterface

// File: rtl/spad_arbiter.sv
// spad_arbiter: independent 2-way round-robin arbitration of read and write
// access to a single-port-per-direction scratchpad with 1-cycle read latency.
// Optional macro SPAD_ARB_WR_BYPASS_EN forwards same-cycle, same-address
// write data to the read response instead of the scratchpad's pre-write data.
module spad_arbiter #(
  parameter int unsigned DATA_BITWIDTH = 16,
  parameter int unsigned ADDR_BITWIDTH = 9
) (
  input  logic          clk,
  input  logic          reset,
  spad_arbiter_if.slave bus
);

  localparam int unsigned DW = DATA_BITWIDTH;
  localparam int unsigned AW = ADDR_BITWIDTH;

  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    rd_gnt_c;
  logic [1:0]    wr_gnt_c;
  logic [1:0]    rd_valid_q;
  logic [DW-1:0] rd_src_c;

  // Favoured requester wins if requesting, otherwise the other one.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
    logic [1:0] gnt;
    gnt = 2'b00;
    if (ptr == 1'b0) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end else begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end
    return gnt;
  endfunction

  // Grant generation, suppressed while reset is held.
  always_comb begin
    rd_gnt_c = 2'b00;
    wr_gnt_c = 2'b00;
    if (reset) begin
      rd_gnt_c = rr_pick(bus.rd_req, rd_ptr);
      wr_gnt_c = rr_pick(bus.wr_req, wr_ptr);
    end
  end

  // Scratchpad port muxing from the granted requester; zero when idle.
  always_comb begin
    bus.sp_r_addr = '0;
    bus.sp_w_addr = '0;
    bus.sp_w_data = '0;
    if (rd_gnt_c[0])      bus.sp_r_addr = bus.rd_addr[0  +: AW];
    else if (rd_gnt_c[1]) bus.sp_r_addr = bus.rd_addr[AW +: AW];
    if (wr_gnt_c[0]) begin
      bus.sp_w_addr = bus.wr_addr[0  +: AW];
      bus.sp_w_data = bus.wr_data[0  +: DW];
    end else if (wr_gnt_c[1]) begin
      bus.sp_w_addr = bus.wr_addr[AW +: AW];
      bus.sp_w_data = bus.wr_data[DW +: DW];
    end
  end

  assign bus.rd_gnt      = rd_gnt_c;
  assign bus.wr_gnt      = wr_gnt_c;
  assign bus.sp_read_req = |rd_gnt_c;
  assign bus.sp_write_en = |wr_gnt_c;

  // Pointers move to the non-granted requester; response valid tracks the grant.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_valid_q <= 2'b00;
    end else begin
      if (|rd_gnt_c) rd_ptr <= rd_gnt_c[0];
      if (|wr_gnt_c) wr_ptr <= wr_gnt_c[0];
      rd_valid_q <= rd_gnt_c;
    end
  end

`ifdef SPAD_ARB_WR_BYPASS_EN
  logic          byp_hit_q;
  logic [DW-1:0] byp_data_q;

  // Capture write data when a read and write hit the same address together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_hit_q  <= bus.sp_read_req && bus.sp_write_en &&
                    (bus.sp_r_addr == bus.sp_w_addr);
      byp_data_q <= bus.sp_w_data;
    end
  end

  // Response source: forwarded write data on a hit, scratchpad otherwise.
  always_comb begin
    rd_src_c = bus.sp_r_data;
    if (byp_hit_q) rd_src_c = byp_data_q;
  end
`else
  // Response source: scratchpad read data (read-before-write semantics).
  always_comb begin
    rd_src_c = bus.sp_r_data;
  end
`endif

  // A response still in flight when reset asserts is squashed immediately.
  assign bus.rd_valid = reset ? rd_valid_q : 2'b00;
  assign bus.rd_data  = (|bus.rd_valid) ? rd_src_c : '0;

endmodule
